// File: rtl/tx_shift_ctrl_if.sv
// Byte handshake, flex_sr control and serial line signals of the USB TX bit sequencer.
// The master side is the TX FSM / shift register / encoder environment; the slave side is tx_shift_ctrl.
interface tx_shift_ctrl_if;
    logic byte_valid;
    logic last_byte;
    logic byte_ready;
    logic sr_load;
    logic sr_shift_en;
    logic sr_serial_out;
    logic tx_bit;
    logic tx_strobe;
    logic busy;
    logic done;
    logic underrun;

    modport master (
        output byte_valid, last_byte, sr_serial_out,
        input  byte_ready, sr_load, sr_shift_en, tx_bit, tx_strobe, busy, done, underrun
    );

    modport slave (
        input  byte_valid, last_byte, sr_serial_out,
        output byte_ready, sr_load, sr_shift_en, tx_bit, tx_strobe, busy, done, underrun
    );
endinterface

// File: rtl/tx_shift_ctrl.sv
// USB TX bit sequencer: paces flex_sr shifting at CLKS_PER_BIT clocks per bit, LSB first.
// Define TX_BIT_STUFF_EN to insert a 0 stuff bit after six consecutive 1s.
//
// state | meaning
// IDLE  | waiting for a byte; byte_ready held high
// SHIFT | sending a data bit for one bit period
// STUFF | sending an inserted 0 after six 1s (TX_BIT_STUFF_EN only)
module tx_shift_ctrl #(
    parameter int NUM_BITS     = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input logic          clk,
    input logic          n_rst,
    tx_shift_ctrl_if.slave bus
);
    localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (NUM_BITS > 2) ? $clog2(NUM_BITS) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] B_LAST = BW'(NUM_BITS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, STUFF} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [BW-1:0] bitcnt_q, bitcnt_d;
    logic          last_q, last_d;
    logic          tx_bit_q, tx_bit_d;
    logic          byte_ready;
    logic          shift_en;
    logic          strobe;
    logic          done;
    logic          underrun;
    logic          advance;
`ifdef TX_BIT_STUFF_EN
    localparam logic [2:0] ONES_MAX = 3'd6;
    logic [2:0]    ones_q, ones_d, ones_nxt;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            bitcnt_q <= '0;
            last_q   <= 1'b0;
            tx_bit_q <= 1'b1;
`ifdef TX_BIT_STUFF_EN
            ones_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            bitcnt_q <= bitcnt_d;
            last_q   <= last_d;
            tx_bit_q <= tx_bit_d;
`ifdef TX_BIT_STUFF_EN
            ones_q   <= ones_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bitcnt_d   = bitcnt_q;
        last_d     = last_q;
        tx_bit_d   = tx_bit_q;
        byte_ready = 1'b0;
        shift_en   = 1'b0;
        strobe     = 1'b0;
        done       = 1'b0;
        underrun   = 1'b0;
        advance    = 1'b0;
`ifdef TX_BIT_STUFF_EN
        ones_d     = ones_q;
        ones_nxt   = tx_bit_q ? (ones_q + 3'd1) : 3'd0;
`endif

        case (state_q)
            IDLE: begin
                byte_ready = 1'b1;
                if (bus.byte_valid) begin
                    state_d  = SHIFT;
                    timer_d  = '0;
                    bitcnt_d = '0;
                    last_d   = bus.last_byte;
                end
            end
            SHIFT: begin
                timer_d = timer_q + TW'(1);
                if (timer_q == '0) begin
                    strobe   = 1'b1;
                    tx_bit_d = bus.sr_serial_out;
                end
                if (timer_q == T_LAST) begin
`ifdef TX_BIT_STUFF_EN
                    ones_d = ones_nxt;
                    // the bit counter and shift wait until the stuff bit is out
                    if (ones_nxt == ONES_MAX) begin
                        state_d = STUFF;
                        timer_d = '0;
                    end else begin
                        advance = 1'b1;
                    end
`else
                    advance = 1'b1;
`endif
                end
            end
`ifdef TX_BIT_STUFF_EN
            STUFF: begin
                timer_d = timer_q + TW'(1);
                if (timer_q == '0) begin
                    strobe   = 1'b1;
                    tx_bit_d = 1'b0;
                    ones_d   = '0;
                end
                if (timer_q == T_LAST) begin
                    advance = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // end of a bit period with no stuff pending: next bit, next byte, or finish
        if (advance) begin
            timer_d = '0;
            if (bitcnt_q != B_LAST) begin
                shift_en = 1'b1;
                bitcnt_d = bitcnt_q + BW'(1);
                state_d  = SHIFT;
            end else if (!last_q) begin
                byte_ready = 1'b1;
                if (bus.byte_valid) begin
                    bitcnt_d = '0;
                    last_d   = bus.last_byte;
                    state_d  = SHIFT;
                end else begin
                    underrun = 1'b1;
                    state_d  = IDLE;
                end
            end else begin
                done    = 1'b1;
                state_d = IDLE;
            end
        end

`ifdef TX_BIT_STUFF_EN
        if (state_d == IDLE) begin
            ones_d = '0;
        end
`endif
    end

    assign bus.byte_ready  = byte_ready;
    assign bus.sr_load     = bus.byte_valid & byte_ready;
    assign bus.sr_shift_en = shift_en;
    assign bus.tx_bit      = tx_bit_q;
    assign bus.tx_strobe   = strobe;
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done;
    assign bus.underrun    = underrun;
endmodule

// File: tb/tb_tx_shift_ctrl.sv
// Self-checking bench for tx_shift_ctrl with a behavioural flex_sr and a bit-stream reference model.
// Follows TX_BIT_STUFF_EN in the same way as the design.
module tb_tx_shift_ctrl;
    localparam int NB  = 8;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    tx_shift_ctrl_if bus ();

    tx_shift_ctrl #(.NUM_BITS(NB), .CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    // behavioural flex_sr: parallel load, shift toward the LSB output
    logic [NB-1:0] sr_q;
    logic [NB-1:0] data_in;
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst)               sr_q <= '1;
        else if (bus.sr_load)     sr_q <= data_in;
        else if (bus.sr_shift_en) sr_q <= {1'b1, sr_q[NB-1:1]};
    end
    assign bus.sr_serial_out = sr_q[0];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int strobe_q[$];
    bit bit_q[$];
    int hs_q[$];
    int done_q[$];
    int und_q[$];
    int shift_cnt = 0;
    bit pend = 1'b0;

    always @(negedge clk) begin
        if (!n_rst) begin
            pend <= 1'b0;
        end else begin
            if (pend) bit_q.push_back(bus.tx_bit);
            pend <= bus.tx_strobe;
            if (bus.tx_strobe)   strobe_q.push_back(cyc);
            if (bus.sr_load)     hs_q.push_back(cyc);
            if (bus.done)        done_q.push_back(cyc);
            if (bus.underrun)    und_q.push_back(cyc);
            if (bus.sr_shift_en) shift_cnt <= shift_cnt + 1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    logic [7:0] pkt[16];
    int s_str, s_bit, s_hs, s_done, s_und, s_shift, fall_cyc;

    task automatic run_packet(input string tag, input int nb, input bit fl);
        int k;
        s_str   = strobe_q.size();
        s_bit   = bit_q.size();
        s_hs    = hs_q.size();
        s_done  = done_q.size();
        s_und   = und_q.size();
        s_shift = shift_cnt;
        @(posedge clk); #1;
        for (int i = 0; i < nb; i++) begin
            data_in        = pkt[i];
            bus.last_byte  = (i == nb - 1) ? fl : 1'b0;
            bus.byte_valid = 1'b1;
            k = 0;
            do begin @(negedge clk); k++; end while (!bus.sr_load && k < 1000);
            check({tag, " handshake"}, int'(bus.sr_load), 1);
            @(posedge clk); #1;
        end
        bus.byte_valid = 1'b0;
        bus.last_byte  = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (bus.busy && k < 2000);
        fall_cyc = cyc;
        check({tag, " busy_falls"}, int'(bus.busy), 0);
    endtask

    // reference: line bits are the data bits LSB first, with a 0 after each run of six 1s
    task automatic check_packet(input string tag, input int nb, input bit fl);
        bit exp_b[$];
        int ones, hs0, err_t, err_b, evt, n;
        ones = 0;
        for (int i = 0; i < nb; i++) begin
            for (int j = 0; j < NB; j++) begin
                exp_b.push_back(pkt[i][j]);
`ifdef TX_BIT_STUFF_EN
                ones = pkt[i][j] ? ones + 1 : 0;
                if (ones == 6) begin
                    exp_b.push_back(1'b0);
                    ones = 0;
                end
`endif
            end
        end
        hs0 = (hs_q.size() > s_hs) ? hs_q[s_hs] : -1000;
        n   = strobe_q.size() - s_str;
        check({tag, " strobe_count"}, n, exp_b.size());
        err_t = 0;
        err_b = 0;
        for (int k = 0; k < n && k < exp_b.size(); k++) begin
            if (strobe_q[s_str + k] != hs0 + 1 + CPB * k) err_t++;
            if (s_bit + k < bit_q.size() && bit_q[s_bit + k] != exp_b[k]) err_b++;
        end
        check({tag, " strobe_timing_errors"}, err_t, 0);
        check({tag, " bit_errors"}, err_b, 0);
        check({tag, " shift_pulses"}, shift_cnt - s_shift, (NB - 1) * nb);
        evt = hs0 + CPB * exp_b.size();
        check({tag, " done_count"}, done_q.size() - s_done, fl ? 1 : 0);
        check({tag, " underrun_count"}, und_q.size() - s_und, fl ? 0 : 1);
        if (done_q.size() > s_done) check({tag, " done_cycle"}, done_q[s_done], evt);
        if (und_q.size() > s_und)   check({tag, " underrun_cycle"}, und_q[s_und], evt);
        check({tag, " busy_fall_cycle"}, fall_cyc, evt + 1);
    endtask

    typedef struct {
        logic [7:0]  data;
        int          exp_n;
        logic [15:0] exp_bits;
    } vec_t;
    vec_t tbl[7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int k, s0, hs_gap, n;
        logic [15:0] got;
        bus.byte_valid = 1'b0;
        bus.last_byte  = 1'b0;
        data_in        = '0;

        // single last-byte vectors: line bits packed LSB first
`ifdef TX_BIT_STUFF_EN
        tbl[0] = '{8'hA5, 8, 16'h00A5};
        tbl[1] = '{8'h3F, 9, 16'h003F};
        tbl[2] = '{8'hFF, 9, 16'h01BF};
        tbl[3] = '{8'h00, 8, 16'h0000};
        tbl[4] = '{8'h7E, 9, 16'h007E};
`else
        tbl[0] = '{8'hA5, 8, 16'h00A5};
        tbl[1] = '{8'h3F, 8, 16'h003F};
        tbl[2] = '{8'hFF, 8, 16'h00FF};
        tbl[3] = '{8'h00, 8, 16'h0000};
        tbl[4] = '{8'h7E, 8, 16'h007E};
`endif
        // ends with five 1s; the next packet must start its run count from zero
        tbl[5] = '{8'hF8, 8, 16'h00F8};
        tbl[6] = '{8'h01, 8, 16'h0001};

        repeat (3) @(negedge clk);
        check("in_reset byte_ready", int'(bus.byte_ready), 1);
        check("in_reset tx_bit", int'(bus.tx_bit), 1);
        #2 n_rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle byte_ready", int'(bus.byte_ready), 1);
            check("idle busy", int'(bus.busy), 0);
            check("idle tx_bit", int'(bus.tx_bit), 1);
            check("idle tx_strobe", int'(bus.tx_strobe), 0);
        end

        for (int i = 0; i < 7; i++) begin
            pkt[0] = tbl[i].data;
            run_packet("vec", 1, 1'b1);
            n = strobe_q.size() - s_str;
            got = '0;
            for (int b = 0; b < n && b < 16 && s_bit + b < bit_q.size(); b++) got[b] = bit_q[s_bit + b];
            check("vec strobes", n, tbl[i].exp_n);
            check("vec bits", int'(got), int'(tbl[i].exp_bits));
            check("vec done_offset", (done_q.size() > s_done && hs_q.size() > s_hs) ?
                  done_q[s_done] - hs_q[s_hs] : -1, CPB * tbl[i].exp_n);
            check("vec shifts", shift_cnt - s_shift, NB - 1);
        end

        // back-to-back 0xFF (not last) then 0x01 (last)
        pkt[0] = 8'hFF;
        pkt[1] = 8'h01;
        run_packet("b2b", 2, 1'b1);
        check_packet("b2b", 2, 1'b1);
        hs_gap = (hs_q.size() > s_hs + 1) ? hs_q[s_hs + 1] - hs_q[s_hs] : -1;
`ifdef TX_BIT_STUFF_EN
        check("b2b second_handshake", hs_gap, CPB * 9);
`else
        check("b2b second_handshake", hs_gap, CPB * 8);
`endif

        // non-last byte with nothing following
        pkt[0] = 8'h00;
        run_packet("underrun", 1, 1'b0);
        check_packet("underrun", 1, 1'b0);

        // reset asserted during bit 3
        s0 = strobe_q.size();
        @(posedge clk); #1;
        data_in = 8'hA5; bus.last_byte = 1'b1; bus.byte_valid = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!bus.sr_load && k < 100);
        @(posedge clk); #1;
        bus.byte_valid = 1'b0; bus.last_byte = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (strobe_q.size() - s0 < 4 && k < 100);
        check("midrst reached_bit3", strobe_q.size() - s0, 4);
        #2 n_rst = 1'b0;
        #1;
        check("midrst busy", int'(bus.busy), 0);
        check("midrst tx_bit", int'(bus.tx_bit), 1);
        check("midrst tx_strobe", int'(bus.tx_strobe), 0);
        check("midrst byte_ready", int'(bus.byte_ready), 1);
        check("midrst shift_en", int'(bus.sr_shift_en), 0);
        check("midrst done", int'(bus.done), 0);
        repeat (3) @(negedge clk);
        #2 n_rst = 1'b1;
        pkt[0] = 8'h3C;
        run_packet("after_rst", 1, 1'b1);
        check_packet("after_rst", 1, 1'b1);

        // randomized packets, biased toward 0xFF to exercise stuffing across bytes
        for (int t = 0; t < 25; t++) begin
            int nb;
            bit fl;
            nb = $urandom_range(1, 4);
            fl = ($urandom_range(0, 4) != 0);
            for (int i = 0; i < nb; i++)
                pkt[i] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
            run_packet("rand", nb, fl);
            check_packet("rand", nb, fl);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
